// File: rtl/proc_rr_scheduler_if.sv
// Control-side bundle of the round-robin scheduler:
// ready mask, yield and quantum in; process numbers and status out.
interface proc_rr_scheduler_if #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_PROCS  = 4
);
   logic                  enable;
   logic [NUM_PROCS-1:0]  ready_mask;
   logic                  yield;
   logic [DATA_WIDTH-1:0] quantum_len;
   logic [DATA_WIDTH-1:0] new_proc_num;
   logic [DATA_WIDTH-1:0] cur_proc_num;
   logic                  busy;
   logic [DATA_WIDTH-1:0] switch_count;

   modport master (
      output enable,
      output ready_mask,
      output yield,
      output quantum_len,
      input  new_proc_num,
      input  cur_proc_num,
      input  busy,
      input  switch_count
   );

   modport slave (
      input  enable,
      input  ready_mask,
      input  yield,
      input  quantum_len,
      output new_proc_num,
      output cur_proc_num,
      output busy,
      output switch_count
   );
endinterface

// File: rtl/proc_rr_scheduler.sv
// Round-robin process scheduler: time-slices ready processes and
// emits a one-cycle process ID pulse at every context switch.
module proc_rr_scheduler #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_PROCS  = 4,
   parameter int IDX_WIDTH  = 2
) (
   input logic                single_clk,
   input logic                reset,
   proc_rr_scheduler_if.slave sif
);
   typedef enum logic [1:0] {
      IDLE,
      SELECT,
      ANNOUNCE,
      RUN
   } state_t;

   state_t                state_q;
   state_t                state_d;
   logic [IDX_WIDTH-1:0]  cur_idx_q;
   logic [DATA_WIDTH-1:0] cur_q;
   logic [DATA_WIDTH-1:0] new_q;
   logic [DATA_WIDTH-1:0] sw_q;
   logic [DATA_WIDTH-1:0] qcnt_q;

   int                    srch_start;
   logic [IDX_WIDTH-1:0]  probe;
   logic [IDX_WIDTH-1:0]  pick_idx;
   logic                  pick_hit;
   logic [DATA_WIDTH-1:0] pick_id;
   logic [DATA_WIDTH-1:0] q_load;
   logic                  cur_rdy;

   // Search begins just past the current process; index 0 before any grant.
   always_comb begin
      pick_idx   = '0;
      pick_hit   = 1'b0;
      probe      = '0;
      srch_start = (cur_q == '0) ? 0
                 : (int'(cur_idx_q) + 1) % NUM_PROCS;
      for (int i = 0; i < NUM_PROCS; i++) begin
         probe = IDX_WIDTH'((srch_start + i) % NUM_PROCS);
         if (!pick_hit && sif.ready_mask[probe]) begin
            pick_hit = 1'b1;
            pick_idx = probe;
         end
      end
   end

   assign pick_id = {{(DATA_WIDTH-IDX_WIDTH){1'b0}}, pick_idx}
                  + DATA_WIDTH'(1);
   assign q_load  = (sif.quantum_len == '0) ? DATA_WIDTH'(1)
                  : sif.quantum_len;
   assign cur_rdy = sif.ready_mask[cur_idx_q];

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (sif.enable && |sif.ready_mask)
               state_d = SELECT;
         end
         SELECT: begin
            state_d = pick_hit ? ANNOUNCE : IDLE;
         end
         ANNOUNCE: begin
            state_d = RUN;
         end
         RUN: begin
            // A dropped ready bit wins even while the slice is frozen.
            if (!cur_rdy)
               state_d = SELECT;
            else if (sif.enable &&
                     (sif.yield || qcnt_q == DATA_WIDTH'(1)))
               state_d = SELECT;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge single_clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cur_idx_q <= '0;
         cur_q     <= '0;
         new_q     <= '0;
         sw_q      <= '0;
         qcnt_q    <= '0;
      end else begin
         state_q <= state_d;
         new_q   <= '0;
         if (state_q == SELECT && pick_hit) begin
            cur_idx_q <= pick_idx;
            cur_q     <= pick_id;
            new_q     <= pick_id;
            sw_q      <= sw_q + DATA_WIDTH'(1);
            qcnt_q    <= q_load;
         end else if (state_q == RUN && sif.enable) begin
            qcnt_q <= qcnt_q - DATA_WIDTH'(1);
         end
      end
   end

   assign sif.new_proc_num = new_q;
   assign sif.cur_proc_num = cur_q;
   assign sif.switch_count = sw_q;
   assign sif.busy         = (state_q != IDLE);
endmodule
